mips_mult_div: RTL and testbench

- Iterative multiply/divide unit for the MIPS32 datapath, with its own HI/LO registers.
- Sits directly downstream of the 32x32 register file and consumes its two read-port values (rs, rt).
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, and handles MTHI/MTLO writes.
- HI/LO feed the MFHI/MFLO write-back mux, which in turn drives the register-file write port.

---
 rtl/mips_mult_div.sv | 181 ++++++++++++++++++
 tb/tb_mips_mult_div.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mips_mult_div.sv
// Iterative MIPS32 multiply/divide unit with private HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mips_mult_div #(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] HILO_RST = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] rs_in,
   input  logic [DATA_W-1:0] rt_in,
   input  logic              mthi,
   input  logic              mtlo,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

   // Two's-complement negation at operand width.
   function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
      return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation at product width.
   function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
      return ~v + {{(2*DATA_W-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude for signed ops, raw value for unsigned ops.
   function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] v,
                                               input logic              is_signed);
      return (is_signed && v[DATA_W-1]) ? neg_w(v) : v;
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                op_div_r;
   logic                neg_a_r;
   logic                neg_b_r;
   logic [DATA_W-1:0]   mag_a_r;
   logic [DATA_W-1:0]   mag_b_r;
   logic [2*DATA_W-1:0] acc_r;
   logic [DATA_W-1:0]   hi_r;
   logic [DATA_W-1:0]   lo_r;
   logic                done_r;

   logic [DATA_W:0]     mul_sum_s;
   logic [DATA_W:0]     div_trial_s;
   logic [DATA_W:0]     div_diff_s;
   logic                div_ge_s;
   logic [2*DATA_W-1:0] calc_acc_s;
   logic [2*DATA_W-1:0] prod_fix_s;
   logic [DATA_W-1:0]   fix_hi_s;
   logic [DATA_W-1:0]   fix_lo_s;
   logic                start_signed_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_CALC;
            else       state_nxt_s = ST_IDLE;
         end
         ST_CALC: begin
            if (cnt_r == CNT_LAST) state_nxt_s = ST_FIX;
            else                   state_nxt_s = ST_CALC;
         end
         ST_FIX:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      busy   = (state_r != ST_IDLE);
      done   = done_r;
      hi_out = hi_r;
      lo_out = lo_r;
   end

   // Iteration step and sign-corrected results.
   always_comb begin
      start_signed_s = ~op[0];
      mul_sum_s   = {1'b0, acc_r[2*DATA_W-1:DATA_W]}
                  + (acc_r[0] ? {1'b0, mag_a_r} : {(DATA_W+1){1'b0}});
      // Upper half is the partial remainder, lower half the dividend shifting into quotient.
      div_trial_s = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
      div_ge_s    = (div_trial_s >= {1'b0, mag_b_r});
      div_diff_s  = div_trial_s - {1'b0, mag_b_r};
      if (op_div_r) begin
         if (div_ge_s) calc_acc_s = {div_diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
         else          calc_acc_s = {acc_r[2*DATA_W-2:0], 1'b0};
      end else begin
         calc_acc_s = {mul_sum_s, acc_r[DATA_W-1:1]};
      end
      prod_fix_s = (neg_a_r ^ neg_b_r) ? neg_2w(acc_r) : acc_r;
      if (!op_div_r) begin
         fix_hi_s = prod_fix_s[2*DATA_W-1:DATA_W];
         fix_lo_s = prod_fix_s[DATA_W-1:0];
      end else if (mag_b_r == {DATA_W{1'b0}}) begin
         // Divide by zero: all-ones quotient, dividend returned unchanged.
         fix_lo_s = {DATA_W{1'b1}};
         fix_hi_s = neg_a_r ? neg_w(mag_a_r) : mag_a_r;
      end else begin
         fix_lo_s = (neg_a_r ^ neg_b_r) ? neg_w(acc_r[DATA_W-1:0]) : acc_r[DATA_W-1:0];
         fix_hi_s = neg_a_r ? neg_w(acc_r[2*DATA_W-1:DATA_W]) : acc_r[2*DATA_W-1:DATA_W];
      end
   end

   // Datapath registers, HI/LO and the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= {CNT_W{1'b0}};
         op_div_r <= 1'b0;
         neg_a_r  <= 1'b0;
         neg_b_r  <= 1'b0;
         mag_a_r  <= {DATA_W{1'b0}};
         mag_b_r  <= {DATA_W{1'b0}};
         acc_r    <= {(2*DATA_W){1'b0}};
         hi_r     <= HILO_RST;
         lo_r     <= HILO_RST;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  op_div_r <= op[1];
                  neg_a_r  <= start_signed_s & rs_in[DATA_W-1];
                  neg_b_r  <= start_signed_s & rt_in[DATA_W-1];
                  mag_a_r  <= mag_w(rs_in, start_signed_s);
                  mag_b_r  <= mag_w(rt_in, start_signed_s);
                  // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
                  acc_r    <= {{DATA_W{1'b0}},
                               op[1] ? mag_w(rs_in, start_signed_s) : mag_w(rt_in, start_signed_s)};
                  cnt_r    <= {CNT_W{1'b0}};
               end else begin
                  if (mthi) hi_r <= rs_in;
                  if (mtlo) lo_r <= rs_in;
               end
            end
            ST_CALC: begin
               acc_r <= calc_acc_s;
               cnt_r <= cnt_r + CNT_ONE;
            end
            ST_FIX: begin
               hi_r   <= fix_hi_s;
               lo_r   <= fix_lo_s;
               done_r <= 1'b1;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mult_div.sv
// Directed self-checking bench for mips_mult_div: results, latency, busy protection, reset abort.
module tb_mips_mult_div;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_in;
   logic [31:0] rt_in;
   logic        mthi;
   logic        mtlo;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int tests_run;
   int tests_failed;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   mips_mult_div #(.DATA_W(32), .HILO_RST(32'h0000_0000)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs_in  (rs_in),
      .rt_in  (rt_in),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .busy   (busy),
      .done   (done),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) on negedges until done is seen; counts edges and busy samples.
   task automatic wait_done(input string tag, inout int ncyc, inout int bcnt);
      while (done !== 1'b1 && ncyc < 100) begin
         @(negedge clk);
         ncyc++;
         if (busy === 1'b1) bcnt++;
      end
      if (done !== 1'b1) check_val({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   // Called at a negedge; starts an op, returns at the negedge where done is visible.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int ncyc;
      int bcnt;
      start = 1'b1; op = o; rs_in = a; rt_in = b;
      @(negedge clk);
      start = 1'b0; rs_in = 32'hA5A5_5A5A; rt_in = 32'h0F0F_F0F0;
      ncyc = 0;
      bcnt = (busy === 1'b1) ? 1 : 0;
      wait_done(tag, ncyc, bcnt);
      check_val({tag, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
      check_val({tag, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
      check_val({tag, "_latency"}, 64'(ncyc), 64'd33);
      check_val({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
      check_val({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int ncyc;
      int bcnt;
      int done_seen;
      tests_run = 0; tests_failed = 0;
      rst = 1'b1; start = 1'b0; op = 2'b00; rs_in = 32'd0; rt_in = 32'd0;
      mthi = 1'b0; mtlo = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_done", {63'd0, done}, 64'd0);
      check_val("rst_hi", {32'd0, hi_out}, 64'd0);
      check_val("rst_lo", {32'd0, lo_out}, 64'd0);

      // Consecutive calls start in the done cycle, exercising back-to-back acceptance.
      do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      do_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("divu_7_2",  OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
      do_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      do_op("divu_zero", OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
      do_op("div_zero",  OP_DIV,   32'hFFFF_FFF6, 32'h0000_0000, 32'hFFFF_FFF6, 32'hFFFF_FFFF);

      // Busy protection: start and mthi mid-operation are ignored.
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; rs_in = 32'd3; rt_in = 32'd4;
      @(negedge clk);
      start = 1'b0;
      ncyc = 0; bcnt = 0;
      repeat (4) begin @(negedge clk); ncyc++; end
      start = 1'b1; op = OP_DIVU; rs_in = 32'd9; rt_in = 32'd3;
      @(negedge clk); ncyc++;
      start = 1'b0; mthi = 1'b1; rs_in = 32'h0000_DEAD;
      @(negedge clk); ncyc++;
      mthi = 1'b0;
      wait_done("busy_prot", ncyc, bcnt);
      check_val("busy_prot_latency", 64'(ncyc), 64'd33);
      check_val("busy_prot_hi", {32'd0, hi_out}, 64'd0);
      check_val("busy_prot_lo", {32'd0, lo_out}, 64'd12);
      @(negedge clk);
      check_val("busy_prot_no_restart", {63'd0, busy}, 64'd0);

      // IDLE mthi takes effect on the next cycle; LO untouched.
      mthi = 1'b1; rs_in = 32'h0000_1234;
      @(negedge clk);
      mthi = 1'b0;
      check_val("mthi_hi", {32'd0, hi_out}, 64'h1234);
      check_val("mthi_lo", {32'd0, lo_out}, 64'd12);

      // start + mtlo together: start wins, move dropped.
      start = 1'b1; mtlo = 1'b1; op = OP_MULTU; rs_in = 32'd2; rt_in = 32'd3;
      @(negedge clk);
      start = 1'b0; mtlo = 1'b0;
      check_val("start_mtlo_busy", {63'd0, busy}, 64'd1);
      check_val("start_mtlo_lo_held", {32'd0, lo_out}, 64'd12);
      ncyc = 0; bcnt = 0;
      wait_done("start_mtlo", ncyc, bcnt);
      check_val("start_mtlo_res_lo", {32'd0, lo_out}, 64'd6);
      check_val("start_mtlo_res_hi", {32'd0, hi_out}, 64'd0);

      // Reset mid-operation abandons the op with no done pulse.
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; rs_in = 32'd100; rt_in = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_busy", {63'd0, busy}, 64'd0);
      check_val("midrst_hi", {32'd0, hi_out}, 64'd0);
      check_val("midrst_lo", {32'd0, lo_out}, 64'd0);
      done_seen = 0;
      repeat (40) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      check_val("midrst_no_done", 64'(done_seen), 64'd0);
      do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
